fc_vec_loader: RTL and testbench

FC_VEC_LOADER -- requirements
Module: fc_vec_loader

---
 rtl/fc_vec_loader.sv | 104 ++++++++++
 tb/tb_fc_vec_loader.sv | 240 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fc_vec_loader.sv
// fc_vec_loader: streams WIDTH-bit elements into a registered IN-wide vector,
// waits SETTLE cycles for the layer, then offers its result. Optional: FC_LOADER_LAST_EN.
module fc_vec_loader #(
  parameter int WIDTH  = 8,
  parameter int IN     = 128,
  parameter int SETTLE = 2,
  localparam int ZW    = WIDTH*2+$clog2(IN)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] s_data,
  input  logic             s_valid,
`ifdef FC_LOADER_LAST_EN
  input  logic             s_last,
`endif
  output logic             s_ready,
  output logic [WIDTH-1:0] x [0:IN-1],
  input  logic [ZW-1:0]    z_in,
  output logic [ZW-1:0]    m_data,
  output logic             m_valid,
  input  logic             m_ready
);

  localparam int IW = $clog2(IN);
  localparam logic [IW-1:0] LAST = IW'(IN-1);
  localparam logic [3:0] CEND = 4'(SETTLE-1);

  typedef enum logic [1:0] {FILL, WAIT, OUT} state_t;

  state_t        state, state_n;
  logic [IW-1:0] idx;
  logic [3:0]    cnt;
  logic          beat;
  logic          tail;
  logic          last_beat;
  logic          done;

  assign s_ready = (state == FILL) && !rst;
  assign beat    = s_valid && s_ready;

`ifdef FC_LOADER_LAST_EN
  assign tail = s_last && (idx != LAST);
`else
  assign tail = 1'b0;
`endif

  assign last_beat = beat && ((idx == LAST) || tail);
  assign done      = (state == WAIT) && (cnt == CEND);

  // state register
  always_ff @(posedge clk) begin
    if (rst) state <= FILL;
    else     state <= state_n;
  end

  // next-state logic
  always_comb begin
    state_n = state;
    unique case (state)
      FILL: if (last_beat) state_n = WAIT;
      WAIT: if (done) state_n = OUT;
      OUT:  if (m_ready) state_n = FILL;
      default: state_n = FILL;
    endcase
  end

  // element index and settle counter
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
      cnt <= '0;
    end else begin
      if (beat) idx <= last_beat ? '0 : idx + 1'b1;
      if (state == WAIT) cnt <= cnt + 1'b1;
      else               cnt <= '0;
    end
  end

  // vector write; a short frame clears the unwritten tail
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int j = 0; j < IN; j++) x[j] <= '0;
    end else if (beat) begin
      for (int j = 0; j < IN; j++) begin
        if (IW'(j) == idx)               x[j] <= s_data;
        else if (tail && (IW'(j) > idx)) x[j] <= '0;
      end
    end
  end

  // result capture and output handshake
  always_ff @(posedge clk) begin
    if (rst) begin
      m_data  <= '0;
      m_valid <= 1'b0;
    end else if (done) begin
      m_data  <= z_in;
      m_valid <= 1'b1;
    end else if ((state == OUT) && m_ready) begin
      m_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_fc_vec_loader.sv
// tb_fc_vec_loader: directed frames with a scoreboard; the bench models
// the layer as the sum of x and checks each emitted result.
module tb_fc_vec_loader;

  localparam int W  = 8;
  localparam int N  = 128;
  localparam int ZW = W*2+$clog2(N);

  logic          clk = 0;
  logic          rst = 1;
  logic [W-1:0]  s_data = '0;
  logic          s_valid = 0;
  logic          s_last = 0;
  logic          s_ready;
  logic [W-1:0]  x [0:N-1];
  logic [ZW-1:0] z_in;
  logic [ZW-1:0] m_data;
  logic          m_valid;
  logic          m_ready = 0;

  int checks = 0;
  int errors = 0;
  logic [ZW-1:0] sb [$];
  logic [W-1:0]  mx [0:N-1];
  int mi = 0;

  fc_vec_loader #(.WIDTH(W), .IN(N), .SETTLE(2)) dut (
    .clk(clk),
    .rst(rst),
    .s_data(s_data),
    .s_valid(s_valid),
`ifdef FC_LOADER_LAST_EN
    .s_last(s_last),
`endif
    .s_ready(s_ready),
    .x(x),
    .z_in(z_in),
    .m_data(m_data),
    .m_valid(m_valid),
    .m_ready(m_ready)
  );

  always #5 clk = ~clk;

  // layer model: sum of the vector
  always_comb begin
    logic [ZW-1:0] acc;
    acc = '0;
    for (int i = 0; i < N; i++) acc = acc + ZW'(x[i]);
    z_in = acc;
  end

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // monitor: pop and compare on every output handshake
  always @(negedge clk) begin
    if (!rst && m_valid && m_ready) begin
      checks++;
      if (sb.size() == 0) begin
        errors++;
        $display("FAIL unexpected_output: got %0d expected none", m_data);
      end else begin
        logic [ZW-1:0] e;
        e = sb.pop_front();
        if (m_data !== e) begin
          errors++;
          $display("FAIL m_data: got %0d expected %0d", m_data, e);
        end
      end
    end
  end

  function automatic logic [W-1:0] dval(input int mode, input int i);
    logic [31:0] v;
    case (mode)
      0: v = i;
      1: v = 32'hFF;
      2: v = i + 1;
      3: v = i * 3;
      default: v = 3;
    endcase
    return v[W-1:0];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < N; i++) mx[i] = '0;
    mi = 0;
  endtask

  task automatic send_frame(input int n, input int mode, input bit gaps,
                            input bit uselast);
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        while ($urandom_range(0, 1) == 0) begin
          s_valid = 0;
          @(posedge clk); #1;
        end
      end
      s_valid = 1;
      s_data  = dval(mode, i);
      s_last  = uselast && (i == n-1);
      @(posedge clk); #1;
      mx[mi] = dval(mode, i);
      if (mi == N-1 || s_last) begin
        logic [ZW-1:0] sum;
        for (int j = mi+1; j < N; j++) mx[j] = '0;
        sum = '0;
        for (int j = 0; j < N; j++) sum = sum + ZW'(mx[j]);
        sb.push_back(sum);
        mi = 0;
      end else begin
        mi++;
      end
    end
    s_valid = 0;
    s_last  = 0;
  endtask

  // cycles from the accepted last beat until m_valid is seen
  task automatic wait_mv(output int lat);
    lat = 1;
    while (!m_valid && lat < 20) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic handshake();
    m_ready = 1;
    @(posedge clk); #1;
    m_ready = 0;
  endtask

  function automatic int xbad(input int lo, input int hi,
                              input logic [W-1:0] v);
    int b = 0;
    for (int i = lo; i <= hi; i++) if (x[i] !== v) b++;
    return b;
  endfunction

  initial begin
    int lat;
    model_clear();
    repeat (2) @(posedge clk);
    #1;
    chk("rst_s_ready", s_ready, 0);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_x_zero", xbad(0, N-1, 0), 0);
    chk("rst_m_data", m_data, 0);
    rst = 0;
    #1;
    chk("s_ready_after_rst", s_ready, 1);

    // frame 1: ramp, back to back
    send_frame(N, 0, 0, 0);
    chk("s_ready_after_last", s_ready, 0);
    chk("x5", x[5], 5);
    chk("x127", x[127], 127);
    wait_mv(lat);
    chk("latency_f1", lat, 3);
    chk("sb_f1_const", sb[0], 8128);
    for (int c = 0; c < 10; c++) begin
      @(posedge clk); #1;
      chk("hold_m_valid", m_valid, 1);
      chk("hold_m_data", m_data, 8128);
      chk("hold_s_ready", s_ready, 0);
    end
    handshake();
    chk("s_ready_after_hs", s_ready, 1);
    chk("m_valid_after_hs", m_valid, 0);

    // frame 2: all 0xFF with random gaps
    send_frame(N, 1, 1, 0);
    chk("x_all_ff", xbad(0, N-1, 8'hFF), 0);
    chk("sb_f2_const", sb[0], 32640);
    wait_mv(lat);
    chk("latency_f2", lat, 3);
    handshake();

    // frame 3: aborted by reset after 60 beats
    send_frame(60, 2, 0, 0);
    rst = 1;
    @(posedge clk); #1;
    rst = 0;
    model_clear();
    chk("abort_x_zero", xbad(0, N-1, 0), 0);
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      chk("abort_no_m_valid", m_valid, 0);
    end

    // frame 4: full frame after the abort
    send_frame(N, 3, 0, 0);
    chk("f4_x0", x[0], 0);
    chk("f4_x127", x[127], 125);
    wait_mv(lat);
    chk("latency_f4", lat, 3);
    handshake();

`ifdef FC_LOADER_LAST_EN
    // frame 5: short frame with s_last on beat 10
    send_frame(10, 4, 0, 1);
    chk("short_head", xbad(0, 9, 3), 0);
    chk("short_tail", xbad(10, N-1, 0), 0);
    wait_mv(lat);
    chk("latency_short", lat, 3);
    chk("sb_short_const", sb[0], 30);
    handshake();
`endif

    // frame 6: pending result discarded by reset
    send_frame(N, 1, 0, 0);
    wait_mv(lat);
    chk("latency_f6", lat, 3);
    rst = 1;
    @(posedge clk); #1;
    chk("discard_m_valid", m_valid, 0);
    chk("discard_s_ready", s_ready, 0);
    rst = 0;
    void'(sb.pop_back());
    model_clear();
    m_ready = 1;
    repeat (5) @(posedge clk);
    #1;
    m_ready = 0;
    chk("discard_no_output", m_valid, 0);
    chk("sb_empty", sb.size(), 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
